loop_gain_sched: RTL and testbench

LOOP_GAIN_SCHED -- requirements
Module: loop_gain_sched

---
 rtl/loop_gain_sched_pkg.sv | 25 ++
 rtl/loop_lock_det.sv | 66 ++++++
 rtl/loop_gain_sched.sv | 116 +++++++++++
 tb/tb_loop_gain_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/loop_gain_sched_pkg.sv
// Shared encodings and gain constants for the loop gain scheduler.
package loop_gain_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ACQ   = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

  localparam logic [3:0] ACQ_SH_C1   = 4'd4;
  localparam logic [4:0] ACQ_SH_C2   = 5'd9;
  localparam logic [3:0] TRACK_SH_C1 = 4'd6;
  localparam logic [4:0] TRACK_SH_C2 = 5'd13;

  // IDLE and START share the acquisition gains.
  function automatic logic [3:0] gain_c1(input state_t s);
    return (s == ST_TRACK) ? TRACK_SH_C1 : ACQ_SH_C1;
  endfunction

  function automatic logic [4:0] gain_c2(input state_t s);
    return (s == ST_TRACK) ? TRACK_SH_C2 : ACQ_SH_C2;
  endfunction

endpackage

// File: rtl/loop_lock_det.sv
// Lock detector: saturated |pd|, threshold compare and run/miss counters.
// lock_evt/loss_evt are combinational so the FSM can act on the same sample.
module loop_lock_det
  import loop_gain_sched_pkg::*;
#(
  parameter int PD_W   = 27,
  parameter int LOCK_N = 64,
  parameter int LOSS_N = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   active,
  input  logic                   tracking,
  input  logic                   sample,
  input  logic signed [PD_W-1:0] pd,
  input  logic        [PD_W-2:0] thr,
  output logic                   lock_evt,
  output logic                   loss_evt
);

  localparam int CNT_MAX = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   LOCK_T = CW'(LOCK_N);
  localparam logic [CW-1:0]   LOSS_T = CW'(LOSS_N);
  localparam logic [PD_W-1:0] PD_MIN = {1'b1, {(PD_W-1){1'b0}}};

  logic [PD_W-1:0] neg;
  logic [PD_W-2:0] mag;
  logic            in_thr;
  logic [CW-1:0]   run_cnt, miss_cnt;
  logic [CW-1:0]   run_inc, miss_inc;

  always_comb begin
    neg = -pd;
    // The most negative sample has no positive twin; clamp it.
    if (pd == PD_MIN)
      mag = '1;
    else if (pd[PD_W-1])
      mag = neg[PD_W-2:0];
    else
      mag = pd[PD_W-2:0];
    in_thr = (mag <= thr);
  end

  assign run_inc  = (run_cnt  == '1) ? run_cnt  : run_cnt  + 1'b1;
  assign miss_inc = (miss_cnt == '1) ? miss_cnt : miss_cnt + 1'b1;

  assign lock_evt = active && !tracking && sample && in_thr && (run_inc >= LOCK_T);
  assign loss_evt = active && tracking && sample && !in_thr && (miss_inc >= LOSS_T);

  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      run_cnt  <= '0;
      miss_cnt <= '0;
    end else if (sample) begin
      if (tracking) begin
        run_cnt  <= '0;
        miss_cnt <= (in_thr || loss_evt) ? '0 : miss_inc;
      end else begin
        miss_cnt <= '0;
        run_cnt  <= (!in_thr || lock_evt) ? '0 : run_inc;
      end
    end
  end

endmodule

// File: rtl/loop_gain_sched.sv
// Loop gain scheduler: update strobes, acquisition/track gain switching and lock FSM.
// Define LOOP_GAIN_SCHED_STAT_EN to add the loss_cnt statistics output.
module loop_gain_sched
  import loop_gain_sched_pkg::*;
#(
  parameter int PD_W     = 27,
  parameter int UPD_LOG2 = 3,
  parameter int LOCK_N   = 64,
  parameter int LOSS_N   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic signed [PD_W-1:0] pd,
  input  logic        [PD_W-2:0] thr,
  output logic                   int_en,
  output logic                   out_en,
  output logic                   int_clr,
  output logic        [3:0]      sh_c1,
  output logic        [4:0]      sh_c2,
  output logic                   locked,
  output logic        [1:0]      state
`ifdef LOOP_GAIN_SCHED_STAT_EN
  ,
  output logic        [15:0]     loss_cnt
`endif
);

  localparam logic [UPD_LOG2-1:0] PH_LAST = '1;
  localparam logic [UPD_LOG2-1:0] PH_ONE  = UPD_LOG2'(1);

  state_t              state_q, nxt_state;
  logic [UPD_LOG2-1:0] phase, nxt_phase;
  logic                running, nxt_running, sample;
  logic                lock_evt, loss_evt;

  assign state   = state_q;
  assign running = (state_q == ST_ACQ) || (state_q == ST_TRACK);
  assign sample  = running && (phase == '0);

  loop_lock_det #(
    .PD_W   (PD_W),
    .LOCK_N (LOCK_N),
    .LOSS_N (LOSS_N)
  ) u_lock_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (en && running),
    .tracking (state_q == ST_TRACK),
    .sample   (sample),
    .pd       (pd),
    .thr      (thr),
    .lock_evt (lock_evt),
    .loss_evt (loss_evt)
  );

  always_comb begin
    nxt_state = state_q;
    if (!en)
      nxt_state = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:  nxt_state = ST_START;
        ST_START: nxt_state = ST_ACQ;
        ST_ACQ:   nxt_state = lock_evt ? ST_TRACK : ST_ACQ;
        ST_TRACK: nxt_state = loss_evt ? ST_ACQ : ST_TRACK;
        default:  nxt_state = ST_IDLE;
      endcase
    end
    nxt_running = (nxt_state == ST_ACQ) || (nxt_state == ST_TRACK);
    // Phase sits at 0 through IDLE and START so ACQ opens on an update cycle.
    if (!nxt_running || state_q == ST_START)
      nxt_phase = '0;
    else
      nxt_phase = phase + 1'b1;
  end

  // Outputs are registered from next-state values so they line up with state/phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase   <= '0;
      int_en  <= 1'b0;
      out_en  <= 1'b0;
      int_clr <= 1'b0;
      locked  <= 1'b0;
      sh_c1   <= ACQ_SH_C1;
      sh_c2   <= ACQ_SH_C2;
    end else begin
      state_q <= nxt_state;
      phase   <= nxt_phase;
      int_en  <= nxt_running && (nxt_phase == '0);
      out_en  <= nxt_running && (nxt_phase == PH_ONE);
      int_clr <= (nxt_state == ST_START);
      locked  <= (nxt_state == ST_TRACK);
      // Gains only move on the period boundary, except when leaving the loop.
      if (!nxt_running) begin
        sh_c1 <= ACQ_SH_C1;
        sh_c2 <= ACQ_SH_C2;
      end else if (phase == PH_LAST) begin
        sh_c1 <= gain_c1(nxt_state);
        sh_c2 <= gain_c2(nxt_state);
      end
    end
  end

`ifdef LOOP_GAIN_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      loss_cnt <= '0;
    else if (state_q == ST_TRACK && nxt_state == ST_ACQ && loss_cnt != 16'hFFFF)
      loss_cnt <= loss_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_loop_gain_sched.sv
// Directed bench for loop_gain_sched: strobes, lock/loss, saturation, en drop and reset.
`timescale 1ns/1ps
module tb_loop_gain_sched;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic signed [26:0] pd;
  logic [25:0]       thr;
  logic              int_en, out_en, int_clr, locked;
  logic [3:0]        sh_c1;
  logic [4:0]        sh_c2;
  logic [1:0]        state;
`ifdef LOOP_GAIN_SCHED_STAT_EN
  logic [15:0]       loss_cnt;
`endif

  int  checks   = 0;
  int  failures = 0;
  bit  clr_seen;
  bit  strobe_seen;

  localparam logic signed [26:0] PD_MIN  = {1'b1, 26'd0};
  localparam logic [25:0]        THR_MAX = '1;

  always #62.5 clk = ~clk;

  loop_gain_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pd      (pd),
    .thr     (thr),
    .int_en  (int_en),
    .out_en  (out_en),
    .int_clr (int_clr),
    .sh_c1   (sh_c1),
    .sh_c2   (sh_c2),
    .locked  (locked),
    .state   (state)
`ifdef LOOP_GAIN_SCHED_STAT_EN
    ,
    .loss_cnt(loss_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (int_clr) clr_seen = 1'b1;
    if (int_en || out_en) strobe_seen = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; pd = 27'sd100; thr = 26'd200;
    clr_seen = 1'b0; strobe_seen = 1'b0;
    repeat (3) step();
    check("rst_state",   32'(state),   0);
    check("rst_int_en",  32'(int_en),  0);
    check("rst_int_clr", 32'(int_clr), 0);
    check("rst_locked",  32'(locked),  0);
    check("rst_sh_c1",   32'(sh_c1),   4);
    check("rst_sh_c2",   32'(sh_c2),   9);

    // START for one cycle, then ACQ opening on an update cycle.
    rst_n = 1'b1;
    step();
    check("start_state",   32'(state),   1);
    check("start_int_clr", 32'(int_clr), 1);
    check("start_int_en",  32'(int_en),  0);
    step();
    check("acq_state",   32'(state),   2);
    check("acq_int_en",  32'(int_en),  1);
    check("acq_int_clr", 32'(int_clr), 0);
    check("acq_out_en",  32'(out_en),  0);
    step();
    check("ph1_out_en", 32'(out_en), 1);
    check("ph1_int_en", 32'(int_en), 0);
    repeat (7) step();
    check("period_int_en", 32'(int_en), 1);
    check("period_out_en", 32'(out_en), 0);

    // Two in-threshold updates so far; 62 more reach LOCK_N.
    repeat (62 * 8) step();
    check("pre_lock_locked", 32'(locked), 0);
    check("pre_lock_int_en", 32'(int_en), 1);
    step();
    check("lock_locked",  32'(locked), 1);
    check("lock_state",   32'(state),  3);
    check("lock_sh_hold", 32'(sh_c1),  4);
    repeat (6) step();
    check("lock_sh2_hold", 32'(sh_c2), 9);
    step();
    check("track_sh_c1", 32'(sh_c1), 6);
    check("track_sh_c2", 32'(sh_c2), 13);

    // 15 misses, one hit, then 16 misses; loss only on the last.
    clr_seen = 1'b0;
    for (int i = 0; i < 31; i++) begin
      pd = (i == 15) ? 27'sd0 : -27'sd500;
      repeat (8) step();
    end
    check("pre_loss_locked", 32'(locked), 1);
    check("pre_loss_state",  32'(state),  3);
    pd = -27'sd500;
    step();
    check("loss_state",  32'(state),    2);
    check("loss_locked", 32'(locked),   0);
    check("loss_no_clr", 32'(clr_seen), 0);
`ifdef LOOP_GAIN_SCHED_STAT_EN
    check("stat_loss_cnt", 32'(loss_cnt), 1);
`endif
    repeat (6) step();
    check("loss_sh_hold", 32'(sh_c1), 6);
    step();
    check("loss_sh_c1", 32'(sh_c1), 4);
    check("loss_sh_c2", 32'(sh_c2), 9);

    // Most-negative pd against max threshold must count as in; pd=1 vs thr=0 must not.
    thr = THR_MAX; pd = PD_MIN;
    repeat (63 * 8) step();
    thr = 26'd0; pd = 27'sd1;
    repeat (8) step();
    check("thr0_miss_locked", 32'(locked), 0);
    thr = THR_MAX; pd = PD_MIN;
    repeat (63 * 8) step();
    thr = 26'd0; pd = 27'sd0;
    step();
    check("sat_lock_locked", 32'(locked), 1);

    // Drop en at phase 5 of a TRACK period.
    repeat (7) step();
    check("relock_sh_c1", 32'(sh_c1), 6);
    repeat (5) step();
    en = 1'b0;
    step();
    check("drop_state",  32'(state),  0);
    check("drop_locked", 32'(locked), 0);
    check("drop_int_en", 32'(int_en), 0);
    check("drop_sh_c1",  32'(sh_c1),  4);
    check("drop_sh_c2",  32'(sh_c2),  9);
    strobe_seen = 1'b0;
    repeat (10) step();
    check("idle_no_strobe", 32'(strobe_seen), 0);
    en = 1'b1;
    step();
    check("restart_state",   32'(state),   1);
    check("restart_int_clr", 32'(int_clr), 1);
    step();
    check("restart_int_en", 32'(int_en), 1);

    // Reset mid-period: no strobe in the reset cycle or the one after.
    repeat (3) step();
    rst_n = 1'b0;
    strobe_seen = 1'b0;
    step();
    check("midrst_state", 32'(state), 0);
    rst_n = 1'b1;
    step();
    check("midrst_no_strobe", 32'(strobe_seen), 0);
    check("midrst_start",     32'(state),       1);
`ifdef LOOP_GAIN_SCHED_STAT_EN
    check("stat_after_rst", 32'(loss_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
